// File: rtl/serial_block_in_if.sv
// Byte-in / block-out bus for serial_block_in.
// The master side supplies received bytes and consumes assembled blocks.
// The slave side is the assembler itself.
interface serial_block_in_if #(
  parameter int unsigned BLOCK_BYTES = 1
);
  logic [7:0]               rx_data;
  logic                     new_rx_data;
  logic [BLOCK_BYTES*8-1:0] rx_block;
  logic                     new_rx_block;
  logic                     rx_block_busy;
  logic                     rx_timeout;

  modport master (
    output rx_data, new_rx_data,
    input  rx_block, new_rx_block, rx_block_busy, rx_timeout
  );

  modport slave (
    input  rx_data, new_rx_data,
    output rx_block, new_rx_block, rx_block_busy, rx_timeout
  );
endinterface

// File: rtl/serial_block_in.sv
// Assembles a stream of received bytes into fixed-size blocks.
// Byte 0 lands in lane 0, byte 1 in the top lane, then descending lanes.
// A partial block is dropped (with an rx_timeout strobe) if the gap between
// bytes reaches TIMEOUT_CYCLES; a byte arriving on that cycle wins.
module serial_block_in #(
  parameter int unsigned BLOCK_BYTES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  serial_block_in_if.slave bus
);

  localparam int unsigned CW = $clog2(BLOCK_BYTES) + 1;
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW = BLOCK_BYTES * 8;

  localparam logic [CW-1:0] LAST_K   = CW'(BLOCK_BYTES - 1);
  localparam logic [IW-1:0] IDLE_TO  = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_SAT = IW'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] shadow_q, shadow_d;
  logic [BW-1:0] rx_block_q, rx_block_d;
  logic          new_block_q, new_block_d;
  logic          timeout_q, timeout_d;
  int unsigned   lane;

  // State, counters, shadow and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idle_q      <= '0;
      shadow_q    <= '0;
      rx_block_q  <= '0;
      new_block_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      shadow_q    <= shadow_d;
      rx_block_q  <= rx_block_d;
      new_block_q <= new_block_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state: byte capture, block completion and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idle_d      = idle_q;
    shadow_d    = shadow_q;
    rx_block_d  = rx_block_q;
    new_block_d = 1'b0;
    timeout_d   = 1'b0;
    lane        = (cnt_q == '0) ? 0 : BLOCK_BYTES - 32'(cnt_q);

    if (bus.new_rx_data) begin
      idle_d = '0;
      // Lane select unrolled so every part-select has a constant index.
      for (int unsigned j = 0; j < BLOCK_BYTES; j++) begin
        if (j == lane) shadow_d[j*8 +: 8] = bus.rx_data;
      end
      // cnt_q is 0 in IDLE, so this also covers the single-byte block case.
      if (cnt_q == LAST_K) begin
        rx_block_d  = shadow_d;
        new_block_d = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = COLLECT;
      end
    end else if (state_q == COLLECT) begin
      if (idle_q == IDLE_TO) begin
        timeout_d = 1'b1;
        cnt_d     = '0;
        idle_d    = '0;
        state_d   = IDLE;
      end else if (idle_q != IDLE_SAT) begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign bus.rx_block      = rx_block_q;
  assign bus.new_rx_block  = new_block_q;
  assign bus.rx_block_busy = (state_q == COLLECT);
  assign bus.rx_timeout    = timeout_q;

endmodule

// File: tb/tb_serial_block_in.sv
// Directed bench for serial_block_in: a 4-byte instance with an 8-cycle
// timeout and a 1-byte instance, sharing clock and reset.
module tb_serial_block_in;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;
  int pulses4  = 0;

  serial_block_in_if #(.BLOCK_BYTES(4)) if4 ();
  serial_block_in_if #(.BLOCK_BYTES(1)) if1 ();

  serial_block_in #(.BLOCK_BYTES(4), .TIMEOUT_CYCLES(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  serial_block_in #(.BLOCK_BYTES(1), .TIMEOUT_CYCLES(6)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  // Strobe exclusivity and block-pulse counting on every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((if4.new_rx_block & if4.rx_timeout) !== 1'b0) begin
        failures++;
        $display("FAIL excl4 new_rx_block=%b rx_timeout=%b required not both 1", if4.new_rx_block, if4.rx_timeout);
      end
      checks++;
      if (if1.rx_timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout1 rx_timeout=%b required 0", if1.rx_timeout);
      end
      if (if4.new_rx_block === 1'b1) pulses4++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: called at a negedge, return at the next negedge.
  task automatic send4(input logic [7:0] b);
    if4.rx_data = b; if4.new_rx_data = 1'b1;
    @(negedge clk);
    if4.new_rx_data = 1'b0;
  endtask

  task automatic send1(input logic [7:0] b);
    if1.rx_data = b; if1.new_rx_data = 1'b1;
    @(negedge clk);
    if1.new_rx_data = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if4.rx_data = 8'hFF; if4.new_rx_data = 1'b1;
    if1.rx_data = 8'hEE; if1.new_rx_data = 1'b1;
    cyc(3);
    checks++; if (if4.rx_block !== 32'h0) begin failures++; $display("FAIL rst_block4 got=%h exp=00000000", if4.rx_block); end
    checks++; if (if4.new_rx_block !== 1'b0) begin failures++; $display("FAIL rst_new4 got=%b exp=0", if4.new_rx_block); end
    checks++; if (if4.rx_block_busy !== 1'b0) begin failures++; $display("FAIL rst_busy4 got=%b exp=0", if4.rx_block_busy); end
    checks++; if (if4.rx_timeout !== 1'b0) begin failures++; $display("FAIL rst_to4 got=%b exp=0", if4.rx_timeout); end
    checks++; if (if1.rx_block !== 8'h0) begin failures++; $display("FAIL rst_block1 got=%h exp=00", if1.rx_block); end
    checks++; if (if1.new_rx_block !== 1'b0) begin failures++; $display("FAIL rst_new1 got=%b exp=0", if1.new_rx_block); end
    if4.new_rx_data = 1'b0; if1.new_rx_data = 1'b0;
    rst = 1'b0;
    cyc(1);
    checks++; if (if4.rx_block_busy !== 1'b0) begin failures++; $display("FAIL rst_ignored_busy4 got=%b exp=0", if4.rx_block_busy); end
    checks++; if (if1.rx_block !== 8'h0) begin failures++; $display("FAIL rst_ignored_block1 got=%h exp=00", if1.rx_block); end
  endtask

  task automatic test_spaced_block;
    send4(8'h11);
    checks++; if (if4.rx_block_busy !== 1'b1) begin failures++; $display("FAIL spaced_busy_after11 got=%b exp=1", if4.rx_block_busy); end
    cyc(2);
    send4(8'h22); cyc(2);
    send4(8'h33);
    checks++; if (if4.rx_block !== 32'h0) begin failures++; $display("FAIL spaced_shadow_hidden got=%h exp=00000000", if4.rx_block); end
    cyc(2);
    checks++; if (if4.rx_block_busy !== 1'b1) begin failures++; $display("FAIL spaced_busy_before44 got=%b exp=1", if4.rx_block_busy); end
    send4(8'h44);
    checks++; if (if4.new_rx_block !== 1'b1) begin failures++; $display("FAIL spaced_new got=%b exp=1", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'h22334411) begin failures++; $display("FAIL spaced_block got=%h exp=22334411", if4.rx_block); end
    checks++; if (if4.rx_block_busy !== 1'b0) begin failures++; $display("FAIL spaced_busy_after44 got=%b exp=0", if4.rx_block_busy); end
    cyc(1);
    checks++; if (if4.new_rx_block !== 1'b0) begin failures++; $display("FAIL spaced_new_once got=%b exp=0", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'h22334411) begin failures++; $display("FAIL spaced_block_hold got=%h exp=22334411", if4.rx_block); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send4(b);
      checks++;
      if (if4.new_rx_block !== ((i == 4 || i == 8) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL b2b_new byte=%0d got=%b exp=%b", i, if4.new_rx_block, (i == 4 || i == 8));
      end
      if (i == 4) begin
        checks++; if (if4.rx_block !== 32'h02030401) begin failures++; $display("FAIL b2b_block1 got=%h exp=02030401", if4.rx_block); end
      end
      if (i == 5) begin
        checks++; if (if4.rx_block_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy5 got=%b exp=1", if4.rx_block_busy); end
      end
    end
    checks++; if (if4.rx_block !== 32'h06070805) begin failures++; $display("FAIL b2b_block2 got=%h exp=06070805", if4.rx_block); end
    cyc(1);
  endtask

  task automatic test_timeout;
    send4(8'hAA);
    send4(8'hBB);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      checks++;
      if (if4.rx_timeout !== ((i == 8) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL to_pulse cycle=%0d got=%b exp=%b", i, if4.rx_timeout, (i == 8));
      end
      checks++;
      if (if4.rx_block_busy !== ((i == 8) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL to_busy cycle=%0d got=%b exp=%b", i, if4.rx_block_busy, (i != 8));
      end
    end
    checks++; if (if4.new_rx_block !== 1'b0) begin failures++; $display("FAIL to_new got=%b exp=0", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'h06070805) begin failures++; $display("FAIL to_block_kept got=%h exp=06070805", if4.rx_block); end
    cyc(1);
    checks++; if (if4.rx_timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_once got=%b exp=0", if4.rx_timeout); end
    send4(8'hC1); send4(8'hC2); send4(8'hC3); send4(8'hC4);
    checks++; if (if4.new_rx_block !== 1'b1) begin failures++; $display("FAIL to_clean_new got=%b exp=1", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'hC2C3C4C1) begin failures++; $display("FAIL to_clean_block got=%h exp=C2C3C4C1", if4.rx_block); end
    cyc(1);
  endtask

  task automatic test_timeout_race;
    send4(8'hD1);
    send4(8'hD2);
    cyc(7);
    send4(8'hD3);
    checks++; if (if4.rx_timeout !== 1'b0) begin failures++; $display("FAIL race_to got=%b exp=0", if4.rx_timeout); end
    checks++; if (if4.rx_block_busy !== 1'b1) begin failures++; $display("FAIL race_busy got=%b exp=1", if4.rx_block_busy); end
    cyc(2);
    send4(8'hD4);
    checks++; if (if4.new_rx_block !== 1'b1) begin failures++; $display("FAIL race_new got=%b exp=1", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'hD2D3D4D1) begin failures++; $display("FAIL race_block got=%h exp=D2D3D4D1", if4.rx_block); end
    cyc(1);
  endtask

  task automatic test_async_reset;
    send4(8'hE1);
    send4(8'hE2);
    #2 rst = 1'b1;
    #1;
    checks++; if (if4.rx_block_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", if4.rx_block_busy); end
    checks++; if (if4.rx_block !== 32'h0) begin failures++; $display("FAIL arst_block got=%h exp=00000000", if4.rx_block); end
    checks++; if ((if4.new_rx_block | if4.rx_timeout) !== 1'b0) begin failures++; $display("FAIL arst_strobe new=%b to=%b exp=0", if4.new_rx_block, if4.rx_timeout); end
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    checks++; if ((if4.new_rx_block | if4.rx_timeout | if4.rx_block_busy) !== 1'b0) begin failures++; $display("FAIL arst_release new=%b to=%b busy=%b exp=0", if4.new_rx_block, if4.rx_timeout, if4.rx_block_busy); end
    send4(8'hF1); send4(8'hF2); send4(8'hF3); send4(8'hF4);
    checks++; if (if4.new_rx_block !== 1'b1) begin failures++; $display("FAIL arst_new got=%b exp=1", if4.new_rx_block); end
    checks++; if (if4.rx_block !== 32'hF2F3F4F1) begin failures++; $display("FAIL arst_block_after got=%h exp=F2F3F4F1", if4.rx_block); end
    cyc(1);
  endtask

  task automatic test_single_byte;
    send1(8'h5A);
    checks++; if (if1.new_rx_block !== 1'b1) begin failures++; $display("FAIL one_new got=%b exp=1", if1.new_rx_block); end
    checks++; if (if1.rx_block !== 8'h5A) begin failures++; $display("FAIL one_block got=%h exp=5A", if1.rx_block); end
    checks++; if (if1.rx_block_busy !== 1'b0) begin failures++; $display("FAIL one_busy got=%b exp=0", if1.rx_block_busy); end
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      checks++;
      if ((if1.rx_block_busy | if1.new_rx_block) !== 1'b0) begin
        failures++; $display("FAIL one_idle cycle=%0d busy=%b new=%b exp=0", i, if1.rx_block_busy, if1.new_rx_block);
      end
    end
    send1(8'h3C);
    send1(8'h7E);
    checks++; if (if1.new_rx_block !== 1'b1) begin failures++; $display("FAIL one_b2b_new got=%b exp=1", if1.new_rx_block); end
    checks++; if (if1.rx_block !== 8'h7E) begin failures++; $display("FAIL one_b2b_block got=%h exp=7E", if1.rx_block); end
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    if4.rx_data = '0; if4.new_rx_data = 1'b0;
    if1.rx_data = '0; if1.new_rx_data = 1'b0;
    @(negedge clk);
    test_reset();
    test_spaced_block();
    test_back_to_back();
    test_timeout();
    test_timeout_race();
    test_async_reset();
    test_single_byte();
    checks++;
    if (pulses4 !== 6) begin
      failures++; $display("FAIL pulse_count4 got=%0d exp=6", pulses4);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_block_in.md
SERIAL_BLOCK_IN -- requirements
Module: serial_block_in

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 1: number of bytes per assembled block, legal range 1..256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum number of idle clk cycles allowed between bytes of one block, minimum 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data  input  8  received byte, valid only when new_rx_data=1.
REQ-006 SHALL have port new_rx_data  input  1  one-cycle strobe marking a received byte.
REQ-007 SHALL have port rx_block  output  BLOCK_BYTES*8  last completed block.
REQ-008 SHALL have port new_rx_block  output  1  one-cycle strobe marking rx_block as updated.
REQ-009 SHALL have port rx_block_busy  output  1  high while a partial block is held.
REQ-010 SHALL have port rx_timeout  output  1  one-cycle strobe marking a discarded partial block.

Function
REQ-011 SHALL use states IDLE (no bytes held) and COLLECT (1..BLOCK_BYTES-1 bytes held); rx_block_busy=1 exactly in COLLECT.
REQ-012 SHALL count received bytes k = 0..BLOCK_BYTES-1 within a block; counter width $clog2(BLOCK_BYTES)+1.
REQ-013 SHALL place byte k in rx_block lane (BLOCK_BYTES-k) mod BLOCK_BYTES, lane j = bits [8j+7:8j]; first byte goes to lane 0, second to the top lane, then descending.
REQ-014 SHALL assemble into an internal shadow register; rx_block SHALL change only on block completion.
REQ-015 IDLE + new_rx_data: when BLOCK_BYTES=1, complete the block at once; otherwise store byte 0 and go to COLLECT.
REQ-016 COLLECT + new_rx_data: store the byte; when it is byte BLOCK_BYTES-1, complete the block and return to IDLE.
REQ-017 On completion, in the cycle after the final new_rx_data: rx_block SHALL show the full block and new_rx_block=1 for exactly one cycle.
REQ-018 Back-to-back new_rx_data every cycle SHALL be accepted with no byte loss; a new block's byte 0 MAY arrive in the same cycle new_rx_block is high.
REQ-019 Idle counter SHALL clear on every new_rx_data and increment each COLLECT cycle without new_rx_data.
REQ-020 When the idle counter reaches TIMEOUT_CYCLES in COLLECT: discard the partial block, go to IDLE, pulse rx_timeout for one cycle; rx_block unchanged, new_rx_block=0.
REQ-021 If new_rx_data coincides with the timeout cycle, the byte SHALL win: no timeout, byte stored.
REQ-022 The idle counter SHALL saturate and never wrap; rx_timeout SHALL never fire in IDLE or when BLOCK_BYTES=1.
REQ-023 new_rx_block and rx_timeout SHALL never both be high in the same cycle.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, byte count 0, idle counter 0, rx_block all zeros, new_rx_block=0, rx_block_busy=0, rx_timeout=0.
REQ-025 Reset during COLLECT SHALL discard the partial block with no strobe; the first byte after release SHALL be byte 0.
REQ-026 new_rx_data asserted while rst=1 SHALL be ignored.

Verification
REQ-027 BLOCK_BYTES=4, bytes 11,22,33,44 (hex) spaced 3 cycles -> rx_block=32'h22334411, new_rx_block one cycle after the 44 strobe, busy high from after 11 until after 44.
REQ-028 BLOCK_BYTES=4, 8 bytes 01..08 on consecutive cycles -> two new_rx_block pulses 4 cycles apart, values 32'h04030201-ordered per REQ-013: 32'h02030401 then 32'h06070805.
REQ-029 BLOCK_BYTES=4, TIMEOUT_CYCLES=8, bytes AA,BB then silence -> rx_timeout pulse 8 cycles after BB, busy falls, rx_block keeps its prior value; next 4 bytes form a clean block.
REQ-030 Same setup, third byte arriving exactly on the timeout cycle -> no rx_timeout, block completes normally after a fourth byte.
REQ-031 Assert rst asynchronously (off clock edge) after 2 of 4 bytes -> outputs clear immediately, no strobe; next 4 bytes produce one correct block.
REQ-032 BLOCK_BYTES=1, byte 5A -> rx_block=8'h5A with new_rx_block next cycle, busy stays 0, no rx_timeout over 2*TIMEOUT_CYCLES idle cycles.
